multiplier_booth_sequential: RTL and testbench
==============================================

Name: multiplier_booth_sequential

Overview:
Sequential signed radix-2 Booth multiplier. It is the inverse-operation companion to the team's non-restoring divider and uses the same START/fin handshake and operand style. One Booth step per clock gives a full-precision 2*WIDTH-bit signed product. It serves the neural-network datapath wherever a multi-cycle, area-cheap multiply is acceptable.

Parameters:
WIDTH, 32, operand width in bits (two's complement); product is 2*WIDTH bits.

Ports:
CLOCK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-high reset
START  input  1  request; a new operation is accepted on a 0->1 transition seen while idle
Multiplicand  input  WIDTH  signed operand M, sampled only on the accepting edge
Multiplier  input  WIDTH  signed operand Q, sampled only on the accepting edge
Product  output  2*WIDTH  signed result M*Q, registered
fin  output  1  high while Product holds a completed result
busy  output  1  high while a multiply is in progress

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE; Product=0; fin=0; busy=0; step counter=0; internal A/Q/q_-1/M registers=0.
  - start_prev is cleared to 0, so a START held high through reset release triggers one operation on the first edge.
- Start detect:
  - start_prev registers START every edge.
  - Accept condition: state==IDLE && START==1 && start_prev==0.
  - A level-held START (for example 5 cycles) produces exactly one operation.
- States: IDLE, CALC.
- IDLE -> CALC on the accepting edge k. At that edge:
  - M <= Multiplicand.
  - A (WIDTH+1 bits) <= 0.
  - Qreg <= Multiplier.
  - q_-1 <= 0.
  - count <= 0; fin <= 0; busy <= 1.
  - Product holds its old value.
- CALC, each edge performs one Booth step:
  - {Qreg[0], q_-1} = 01: A <= A + sext(M).
  - {Qreg[0], q_-1} = 10: A <= A - sext(M).
  - 00 or 11: A unchanged.
  - Then arithmetic shift right of {A, Qreg, q_-1} by one. The MSB of A is replicated.
  - count increments.
  - A is WIDTH+1 bits so M = -2^(WIDTH-1) cannot overflow.
- Completion: the step at edge k+WIDTH is the last. At that edge:
  - Product <= low 2*WIDTH bits of the post-shift {A, Qreg} (i.e. {A[WIDTH-1:0], Qreg}).
  - fin <= 1; busy <= 0; state <= IDLE.
- Latency: fin and Product are valid after edge k+WIDTH, which is WIDTH cycles after acceptance.
- fin is a level, not a pulse. It stays high, with Product stable, until the next accepted START, which clears fin on its accepting edge.
- START activity during CALC is ignored: no restart, and operands are not resampled. Changing Multiplicand/Multiplier during CALC has no effect.
- A START rising edge coincident with the completion edge is not accepted, because state is still CALC.
  - start_prev still updates on that edge, so a level-held START will not trigger later either.
  - Requesters must drop START and re-raise it.
- Back-to-back operation: the earliest next acceptance is edge k+WIDTH+1, giving throughput of one result per WIDTH+1 cycles minimum.
- Reset mid-operation: the computation is abandoned immediately (async). All outputs take their reset values, and no partial Product ever appears.
- Arithmetic is exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2). There is no overflow flag.

Test Plan:
- Multiplicand=10, Multiplier=2, START high 5 cycles: exactly one operation; fin rises 32 cycles after acceptance; Product=20; busy high for exactly 32 cycles.
- Multiplicand=10, Multiplier=-3: Product=0xFFFF_FFFF_FFFF_FFE2 (-30). Then Multiplicand=-10, Multiplier=-4: Product=40. Between the two operations, fin clears on the accepting edge of the second.
- Corner values:
  - 0x8000_0000 * 0x8000_0000: Product=0x4000_0000_0000_0000.
  - 0x7FFF_FFFF * 0x8000_0000: Product=0xC000_0000_8000_0000.
  - 0 * 0x1234_5678: Product=0.
- Operands changed and START toggled at cycle 10 of CALC: Product still equals the original operands' product; fin timing unchanged.
- RESET asserted asynchronously at cycle 15 of an operation: Product=0, fin=0, busy=0 immediately. After release, 7 * -6 completes in 32 cycles with Product=-42.
- Randomized self-check: 1000 random signed operand pairs compared against a 64-bit reference multiply, with back-to-back requests issued at the minimum 33-cycle spacing.

Source files
------------

// File: rtl/multiplier_booth_sequential.sv
// Sequential signed radix-2 Booth multiplier, full-precision 2*WIDTH-bit product.
// Latency: Product/fin valid WIDTH cycles after the accepting edge.
// Backpressure: none; START is edge-detected and ignored while busy, fin holds until the next accept.
//
// Ports:
//   CLOCK, RESET        rising-edge clock, asynchronous active-high reset
//   START               request, accepted on a 0->1 transition seen while idle
//   Multiplicand (M)    signed operand, sampled on the accepting edge
//   Multiplier   (Q)    signed operand, sampled on the accepting edge
//   Product             registered signed M*Q
//   fin                 level, high while Product holds a completed result
//   busy                high while a multiply is in progress
module multiplier_booth_sequential #(
    parameter int WIDTH = 32
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 fin,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t               state_q, state_d;
    logic                 start_prev_q, start_prev_d;
    // A carries one guard bit so subtracting M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     qreg_q, qreg_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 fin_q, fin_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       a_sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;
    logic                 qm1_shift;

    always_comb begin
        state_d      = state_q;
        start_prev_d = START;
        a_d          = a_q;
        qreg_d       = qreg_q;
        qm1_d        = qm1_q;
        m_d          = m_q;
        count_d      = count_q;
        product_d    = product_q;
        fin_d        = fin_q;
        busy_d       = busy_q;

        // One Booth step: add/subtract M depending on the bit pair, then
        // arithmetic shift of {A, Q, q_-1} right by one.
        m_ext = {m_q[WIDTH-1], m_q};
        case ({qreg_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase
        {a_shift, q_shift, qm1_shift} = {a_sum[WIDTH], a_sum, qreg_q};

        case (state_q)
            IDLE: begin
                if (START && !start_prev_q) begin
                    state_d = CALC;
                    m_d     = Multiplicand;
                    a_d     = '0;
                    qreg_d  = Multiplier;
                    qm1_d   = 1'b0;
                    count_d = '0;
                    fin_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                a_d     = a_shift;
                qreg_d  = q_shift;
                qm1_d   = qm1_shift;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    product_d = {a_shift[WIDTH-1:0], q_shift};
                    fin_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            a_q          <= '0;
            qreg_q       <= '0;
            qm1_q        <= 1'b0;
            m_q          <= '0;
            count_q      <= '0;
            product_q    <= '0;
            fin_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            a_q          <= a_d;
            qreg_q       <= qreg_d;
            qm1_q        <= qm1_d;
            m_q          <= m_d;
            count_q      <= count_d;
            product_q    <= product_d;
            fin_q        <= fin_d;
            busy_q       <= busy_d;
        end
    end

    assign Product = product_q;
    assign fin     = fin_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_multiplier_booth_sequential.sv
module tb_multiplier_booth_sequential;

    logic        CLOCK;
    logic        RESET;
    logic        START;
    logic [31:0] Multiplicand;
    logic [31:0] Multiplier;
    logic [63:0] Product;
    logic        fin;
    logic        busy;

    int          n_cmp;
    int          n_err;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod;

    multiplier_booth_sequential #(.WIDTH(32)) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .START        (START),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .fin          (fin),
        .busy         (busy)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Count busy cycles over a window; used to prove no spurious restart.
    task automatic idle_window(input int cycles, input string tag);
        int nb;
        nb = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLOCK); #1;
            if (busy) nb++;
        end
        chk(tag, 64'(nb), 64'd0);
    endtask

    // Drive one operation. START rises at a negedge, so the next posedge is
    // the accepting edge k. hold: cycles START stays high. disturb: change
    // operands and toggle START part-way through CALC.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          input int hold, input bit disturb, input string tag);
        int n;
        int nb;
        logic signed [63:0] sm;
        logic signed [63:0] sq;
        logic [63:0] e;
        @(negedge CLOCK);
        Multiplicand = m;
        Multiplier   = q;
        START        = 1'b1;
        sm = $signed(m);
        sq = $signed(q);
        e  = sm * sq;
        exp_q.push_back(e);
        @(posedge CLOCK); #1;
        chk({tag, "_fin_clr"}, 64'(fin), 64'd0);
        chk({tag, "_busy_set"}, 64'(busy), 64'd1);
        chk({tag, "_prod_hold"}, Product, last_prod);
        n  = 0;
        nb = 0;
        while (!fin && n < 100) begin
            if (busy) nb++;
            n++;
            @(negedge CLOCK);
            if (disturb && n == 10) begin
                Multiplicand = ~m;
                Multiplier   = q + 32'd5;
                START        = 1'b1;
            end else if (n >= hold) begin
                START = 1'b0;
            end
            @(posedge CLOCK); #1;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_product"}, Product, e);
            last_prod = e;
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        last_prod    = 64'd0;
        RESET        = 1'b1;
        START        = 1'b0;
        Multiplicand = 32'd0;
        Multiplier   = 32'd0;
        #12;
        chk("rst_product", Product, 64'd0);
        chk("rst_fin", 64'(fin), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Level-held START gives exactly one operation.
        run_op(32'd10, 32'd2, 5, 1'b0, "hold5");
        idle_window(8, "hold5_no_retrigger");

        run_op(32'd10, -32'sd3, 1, 1'b0, "p10_m3");
        chk("m30_value", last_prod, 64'hFFFF_FFFF_FFFF_FFE2);
        run_op(-32'sd10, -32'sd4, 1, 1'b0, "m10_m4");

        run_op(32'h8000_0000, 32'h8000_0000, 1, 1'b0, "min_min");
        chk("min_min_value", last_prod, 64'h4000_0000_0000_0000);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1, 1'b0, "max_min");
        chk("max_min_value", last_prod, 64'hC000_0000_8000_0000);
        run_op(32'd0, 32'h1234_5678, 1, 1'b0, "zero");

        // Operand change and START toggle during CALC are ignored.
        run_op(32'd123, -32'sd456, 1, 1'b1, "disturb");
        idle_window(4, "disturb_no_retrigger");

        // START held across the completion edge must not trigger later.
        run_op(32'd5, 32'd6, 40, 1'b0, "hold_thru_done");
        idle_window(5, "hold_thru_no_retrigger");
        @(negedge CLOCK);
        START = 1'b0;

        // Asynchronous reset mid-operation.
        @(negedge CLOCK);
        Multiplicand = 32'd999;
        Multiplier   = 32'd777;
        START        = 1'b1;
        repeat (15) @(posedge CLOCK);
        #2;
        START = 1'b0;
        RESET = 1'b1;
        #1;
        chk("arst_product", Product, 64'd0);
        chk("arst_fin", 64'(fin), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        last_prod = 64'd0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        run_op(32'd7, -32'sd6, 1, 1'b0, "after_rst");
        chk("after_rst_value", last_prod, 64'hFFFF_FFFF_FFFF_FFD6);

        // Random back-to-back at minimum spacing.
        for (int i = 0; i < 1000; i++) begin
            run_op($urandom, $urandom, 1, 1'b0, "rand");
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
